// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: decodes mult/div/mfhi/mflo/mthi/mtlo
// from INS_E, runs a fixed-latency busy window, then commits HI/LO.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   INS_E            instruction in EX
//   RD1_E, RD2_E     forwarded rs / rt operands
//   Start            mult/multu/div/divu decoded in EX (combinational)
//   Busy             operation in flight (counter != 0)
//   MDU_OUT          HI for mfhi, LO for mflo, else 0 (combinational)
//   HI_O, LO_O       architectural HI / LO registers
module mdu #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INS_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDU_OUT,
  output logic [31:0] HI_O,
  output logic [31:0] LO_O
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [31:0]   hi, lo;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;
  logic [CW-1:0] cnt;

  logic is_r;
  logic op_mult, op_multu, op_div, op_divu;
  logic op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic unused_bits;

  assign is_r        = (INS_E[31:26] == 6'b000000);
  assign unused_bits = ^INS_E[25:6];

  always_comb begin
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    op_mfhi  = 1'b0;
    op_mflo  = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    if (is_r) begin
      case (INS_E[5:0])
        F_MULT:  op_mult  = 1'b1;
        F_MULTU: op_multu = 1'b1;
        F_DIV:   op_div   = 1'b1;
        F_DIVU:  op_divu  = 1'b1;
        F_MFHI:  op_mfhi  = 1'b1;
        F_MFLO:  op_mflo  = 1'b1;
        F_MTHI:  op_mthi  = 1'b1;
        F_MTLO:  op_mtlo  = 1'b1;
        default: ;
      endcase
    end
  end

  assign Start = op_mult | op_multu | op_div | op_divu;
  assign Busy  = (cnt != '0);
  assign HI_O  = hi;
  assign LO_O  = lo;

  always_comb begin
    MDU_OUT = 32'd0;
    if (op_mfhi)      MDU_OUT = hi;
    else if (op_mflo) MDU_OUT = lo;
  end

  // Arithmetic datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] dsor;
  logic        ovf, dz;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{RD1_E[31]}}, RD1_E})
                * $signed({{32{RD2_E[31]}}, RD2_E});
  assign prod_u = {32'd0, RD1_E} * {32'd0, RD2_E};

  // Divisor forced to 1 on divide-by-zero keeps the
  // dividers free of X; the result is discarded anyway.
  assign dz   = (RD2_E == 32'd0);
  assign dsor = dz ? 32'd1 : RD2_E;
  assign ovf  = (RD1_E == 32'h8000_0000) &&
                (RD2_E == 32'hFFFF_FFFF);

  always_comb begin
    if (ovf) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = $signed(RD1_E) / $signed(dsor);
      r_s = $signed(RD1_E) % $signed(dsor);
    end
  end

  assign q_u = RD1_E / dsor;
  assign r_u = RD1_E % dsor;

  logic [31:0]   nxt_hi, nxt_lo;
  logic          nxt_wr;
  logic [CW-1:0] nxt_cnt;

  always_comb begin
    nxt_hi  = 32'd0;
    nxt_lo  = 32'd0;
    nxt_wr  = 1'b1;
    nxt_cnt = CW'(MUL_LAT);
    unique case (1'b1)
      op_mult: begin
        nxt_hi = prod_s[63:32];
        nxt_lo = prod_s[31:0];
      end
      op_multu: begin
        nxt_hi = prod_u[63:32];
        nxt_lo = prod_u[31:0];
      end
      op_div: begin
        nxt_hi  = r_s;
        nxt_lo  = q_s;
        nxt_wr  = ~dz;
        nxt_cnt = CW'(DIV_LAT);
      end
      op_divu: begin
        nxt_hi  = r_u;
        nxt_lo  = q_u;
        nxt_wr  = ~dz;
        nxt_cnt = CW'(DIV_LAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      cnt     <= '0;
    end else if (Busy) begin
      // Start and mthi/mtlo are ignored while busy.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (Start) begin
      pend_hi <= nxt_hi;
      pend_lo <= nxt_lo;
      pend_wr <= nxt_wr;
      cnt     <= nxt_cnt;
    end else if (op_mthi) begin
      hi <= RD1_E;
    end else if (op_mtlo) begin
      lo <= RD1_E;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: table of arithmetic vectors plus
// hand sequences for busy overlap, reset abort and mt hazards.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] INS_E, RD1_E, RD2_E;
  logic        Start, Busy;
  logic [31:0] MDU_OUT, HI_O, LO_O;

  int checks = 0;
  int errors = 0;

  mdu #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset),
    .INS_E(INS_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Start(Start), .Busy(Busy), .MDU_OUT(MDU_OUT),
    .HI_O(HI_O), .LO_O(LO_O)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [31:0] h, input logic [31:0] l);
    INS_E = MTHI; RD1_E = h;
    tick();
    INS_E = MTLO; RD1_E = l;
    tick();
    INS_E = NOP; RD1_E = 0;
  endtask

  task automatic run_vec(input vec_t v);
    preset(v.pre_hi, v.pre_lo);
    INS_E = v.ins; RD1_E = v.a; RD2_E = v.b;
    #1;
    chk({v.name, " start"}, {31'd0, Start}, 32'd1);
    tick();
    INS_E = NOP; RD1_E = 0; RD2_E = 0;
    chk({v.name, " busy0"}, {31'd0, Busy}, 32'd1);
    for (int k = 1; k < v.lat; k++) begin
      tick();
      chk({v.name, " busy"}, {31'd0, Busy}, 32'd1);
    end
    chk({v.name, " old hi"}, HI_O, v.pre_hi);
    chk({v.name, " old lo"}, LO_O, v.pre_lo);
    tick();
    chk({v.name, " done"}, {31'd0, Busy}, 32'd0);
    chk({v.name, " hi"}, HI_O, v.exp_hi);
    chk({v.name, " lo"}, LO_O, v.exp_lo);
    INS_E = MFHI; #1;
    chk({v.name, " mfhi"}, MDU_OUT, v.exp_hi);
    INS_E = MFLO; #1;
    chk({v.name, " mflo"}, MDU_OUT, v.exp_lo);
    INS_E = NOP;
  endtask

  initial begin
    vecs[0]  = '{"mult_neg1x2", MULT, 32'hFFFFFFFF, 32'd2, 32'hA, 32'hB,
                 5, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_ffx2", MULTU, 32'hFFFFFFFF, 32'd2, 32'hA, 32'hB,
                 5, 32'h1, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
                 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7_2", DIVU, 32'd7, 32'd2, 32'h0, 32'h0,
                 10, 32'h1, 32'h3};
    vecs[4]  = '{"div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,
                 10, 32'h0, 32'h80000000};
    vecs[5]  = '{"div_zero", DIV, 32'd9, 32'd0, 32'h11, 32'h22,
                 10, 32'h11, 32'h22};
    vecs[6]  = '{"mult_max", MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0,
                 5, 32'h3FFFFFFF, 32'h00000001};
    vecs[7]  = '{"div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
                 10, 32'h1, 32'hFFFFFFFD};
    vecs[8]  = '{"multu_ffff", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                 32'h0, 5, 32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{"divu_zero", DIVU, 32'd5, 32'd0, 32'h33, 32'h44,
                 10, 32'h33, 32'h44};
    vecs[10] = '{"div_m8_m3", DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h0,
                 32'h0, 10, 32'hFFFFFFFE, 32'h2};

    reset = 1'b1; INS_E = NOP; RD1_E = 0; RD2_E = 0;
    tick();
    tick();
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst hi", HI_O, 32'd0);
    chk("rst lo", LO_O, 32'd0);
    INS_E = MFHI; #1;
    chk("rst mfhi", MDU_OUT, 32'd0);
    INS_E = MULT; #1;
    chk("rst start", {31'd0, Start}, 32'd1);
    INS_E = NOP;
    reset = 1'b0;
    tick();

    // mtlo then mflo sees the new value the next cycle
    INS_E = MTLO; RD1_E = 32'h1234;
    tick();
    INS_E = MFLO; RD1_E = 0; #1;
    chk("mtlo mflo", MDU_OUT, 32'h1234);
    INS_E = MTHI; #1;
    chk("mthi no start", {31'd0, Start}, 32'd0);
    chk("mthi mdu_out", MDU_OUT, 32'd0);
    INS_E = 32'h0400_0018; #1;
    chk("non-r start", {31'd0, Start}, 32'd0);
    INS_E = NOP;

    foreach (vecs[i]) run_vec(vecs[i]);

    // second mult while busy is ignored, no reload
    preset(32'h0, 32'h0);
    INS_E = MULT; RD1_E = 32'd3; RD2_E = 32'd4;
    tick();
    INS_E = NOP;
    tick();
    tick();
    INS_E = MULT; RD1_E = 32'd5; RD2_E = 32'd6; #1;
    chk("ovl start", {31'd0, Start}, 32'd1);
    tick();
    INS_E = NOP;
    tick();
    chk("ovl busy4", {31'd0, Busy}, 32'd1);
    tick();
    chk("ovl busy5", {31'd0, Busy}, 32'd0);
    chk("ovl lo", LO_O, 32'd12);
    for (int k = 0; k < 8; k++) tick();
    chk("ovl late busy", {31'd0, Busy}, 32'd0);
    chk("ovl late lo", LO_O, 32'd12);

    // mtlo held through the busy window incl. commit edge
    preset(32'h0, 32'h0);
    INS_E = MULTU; RD1_E = 32'd2; RD2_E = 32'd3;
    tick();
    INS_E = MTLO; RD1_E = 32'hAAAA;
    for (int k = 1; k < 5; k++) tick();
    chk("mt busy lo", LO_O, 32'd0);
    INS_E = MFLO; #1;
    chk("mflo pending", MDU_OUT, 32'd0);
    INS_E = MTLO;
    tick();
    INS_E = NOP; RD1_E = 0;
    chk("mt commit lo", LO_O, 32'd6);

    // reset in the middle of a div discards it
    preset(32'h55, 32'h66);
    INS_E = DIV; RD1_E = 32'd100; RD2_E = 32'd7;
    tick();
    INS_E = NOP;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort hi", HI_O, 32'd0);
    chk("abort lo", LO_O, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("abort late hi", HI_O, 32'd0);
    chk("abort late lo", LO_O, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
